mem_arbiter: RTL

- Two-requester, round-robin arbiter that shares one single-port memory bus between the PROCESSOR memory port (port 0, "Cpu") and an auxiliary bus master (port 1, "Aux", e.g. loader/DMA/debug).
- Generates the processor's iRDY stall signal.
- Sequences each access with a request/ack handshake to memory.
- Includes a per-access timeout watchdog that releases the bus when memory fails to acknowledge.

---
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the shared memory port and the arbiter.
// The arbiter takes the slave view; the requester/memory side takes the master view.
interface mem_arbiter_if;
    logic [31:0] iCpuAddr;
    logic [31:0] iCpuWData;
    logic        iCpuRead;
    logic        iCpuWrite;
    logic [31:0] oCpuRData;
    logic        oCpuRdy;

    logic [31:0] iAuxAddr;
    logic [31:0] iAuxWData;
    logic        iAuxRead;
    logic        iAuxWrite;
    logic [31:0] oAuxRData;
    logic        oAuxRdy;

    logic [31:0] oMemAddr;
    logic [31:0] oMemWData;
    logic        oMemRead;
    logic        oMemWrite;
    logic [31:0] iMemRData;
    logic        iMemAck;

    logic        iClrErr;
    logic        oTimeout;

    modport slave (
        input  iCpuAddr, iCpuWData, iCpuRead, iCpuWrite,
        output oCpuRData, oCpuRdy,
        input  iAuxAddr, iAuxWData, iAuxRead, iAuxWrite,
        output oAuxRData, oAuxRdy,
        output oMemAddr, oMemWData, oMemRead, oMemWrite,
        input  iMemRData, iMemAck,
        input  iClrErr,
        output oTimeout
    );

    modport master (
        output iCpuAddr, iCpuWData, iCpuRead, iCpuWrite,
        input  oCpuRData, oCpuRdy,
        output iAuxAddr, iAuxWData, iAuxRead, iAuxWrite,
        input  oAuxRData, oAuxRdy,
        input  oMemAddr, oMemWData, oMemRead, oMemWrite,
        output iMemRData, iMemAck,
        output iClrErr,
        input  oTimeout
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the processor (Cpu)
// and an auxiliary master (Aux), with Cpu stall generation and an access watchdog.
module mem_arbiter #(
    parameter int unsigned TO_CYCLES = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
    input  logic         iClk,
    input  logic         iRst,
    mem_arbiter_if.slave bus
);
    localparam int unsigned     TCW     = (TO_CYCLES > 1) ? $clog2(TO_CYCLES + 1) : 1;
    localparam logic [TCW-1:0]  TC_LAST = (TO_CYCLES == 0) ? '0 : TCW'(TO_CYCLES - 1);
    localparam logic            TO_EN   = (TO_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_AUX = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic           last_aux_q, last_aux_d;
    logic [TCW-1:0] tcnt_q, tcnt_d;
    logic           timeout_q, timeout_d;

    logic        cpu_req, aux_req;
    logic        granted, to_hit, done;
    logic [31:0] done_data;

    assign cpu_req   = bus.iCpuRead | bus.iCpuWrite;
    assign aux_req   = bus.iAuxRead | bus.iAuxWrite;
    assign granted   = (state_q != IDLE);
    // An ack in the final watchdog cycle wins, so a late but valid reply is never flagged.
    assign to_hit    = TO_EN && granted && !bus.iMemAck && (tcnt_q == TC_LAST);
    assign done      = granted && (bus.iMemAck || to_hit);
    assign done_data = bus.iMemAck ? bus.iMemRData : ERR_DATA;

    assign bus.oTimeout = timeout_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= IDLE;
            last_aux_q <= 1'b1;
            tcnt_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_aux_q <= last_aux_d;
            tcnt_q     <= tcnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // NOTE: every output of this block gets a default before the case statement,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        last_aux_d    = last_aux_q;
        tcnt_d        = tcnt_q;
        timeout_d     = timeout_q & ~bus.iClrErr;

        bus.oMemAddr  = '0;
        bus.oMemWData = '0;
        bus.oMemRead  = 1'b0;
        bus.oMemWrite = 1'b0;
        bus.oCpuRData = '0;
        bus.oAuxRData = '0;
        bus.oAuxRdy   = 1'b0;
        bus.oCpuRdy   = ~cpu_req;

        unique case (state_q)
            IDLE: begin
                tcnt_d = '0;
                if (cpu_req && (!aux_req || last_aux_q)) begin
                    state_d    = GNT_CPU;
                    last_aux_d = 1'b0;
                end else if (aux_req) begin
                    state_d    = GNT_AUX;
                    last_aux_d = 1'b1;
                end
            end
            GNT_CPU: begin
                bus.oMemAddr  = bus.iCpuAddr;
                bus.oMemWData = bus.iCpuWData;
                bus.oMemWrite = bus.iCpuWrite;
                bus.oMemRead  = bus.iCpuRead & ~bus.iCpuWrite;
                if (done) begin
                    bus.oCpuRdy   = 1'b1;
                    bus.oCpuRData = done_data;
                end
            end
            GNT_AUX: begin
                bus.oMemAddr  = bus.iAuxAddr;
                bus.oMemWData = bus.iAuxWData;
                bus.oMemWrite = bus.iAuxWrite;
                bus.oMemRead  = bus.iAuxRead & ~bus.iAuxWrite;
                if (done) begin
                    bus.oAuxRdy   = 1'b1;
                    bus.oAuxRData = done_data;
                end
            end
            default: state_d = IDLE;
        endcase

        if (granted) begin
            if (done) begin
                state_d = IDLE;
                tcnt_d  = '0;
            end else if (TO_EN) begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end

        if (to_hit) begin
            timeout_d = 1'b1;
        end
    end
endmodule
